// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle of the Execute-stage multiply/divide unit.
// MTHI/MTLO write signals exist only when MULTDIV_MTHILO_EN is defined.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             MultStartE;
    logic             MultOpE;
    logic             MultSgnE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             MultAbortE;
    logic             MultBusyE;
    logic             MultDoneE;
    logic             DivZeroE;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
`ifdef MULTDIV_MTHILO_EN
    logic             HiWriteE;
    logic             LoWriteE;
    logic [WIDTH-1:0] HiLoDataE;
`endif

    modport master (
        output MultStartE, MultOpE, MultSgnE, SrcAE, SrcBE, MultAbortE,
`ifdef MULTDIV_MTHILO_EN
        output HiWriteE, LoWriteE, HiLoDataE,
`endif
        input  MultBusyE, MultDoneE, DivZeroE, HiOut, LoOut
    );

    modport slave (
        input  MultStartE, MultOpE, MultSgnE, SrcAE, SrcBE, MultAbortE,
`ifdef MULTDIV_MTHILO_EN
        input  HiWriteE, LoWriteE, HiLoDataE,
`endif
        output MultBusyE, MultDoneE, DivZeroE, HiOut, LoOut
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) into HI/LO.
// Optional MTHI/MTLO write path is enabled with `define MULTDIV_MTHILO_EN.
module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave mdu
);
    localparam int unsigned BPC = BITS_PER_CYCLE;
    localparam int          N   = WIDTH / BITS_PER_CYCLE;
    localparam int          CW  = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH:0]   opnd;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH:0]   acc_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dz_q;

    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;

`ifdef MULTDIV_MTHILO_EN
    assign hi_wr   = mdu.HiWriteE;
    assign lo_wr   = mdu.LoWriteE;
    assign wr_data = mdu.HiLoDataE;
`else
    assign hi_wr   = 1'b0;
    assign lo_wr   = 1'b0;
    assign wr_data = '0;
`endif

    // Operand magnitudes: WIDTH+1 bits so that |min-int| is representable.
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH:0]   mag_a;
    logic [WIDTH:0]   mag_b;
    logic             accept;
    logic             kill;

    always_comb begin
        neg_a  = mdu.MultSgnE & mdu.SrcAE[WIDTH-1];
        neg_b  = mdu.MultSgnE & mdu.SrcBE[WIDTH-1];
        mag_a  = neg_a ? -{1'b1, mdu.SrcAE} : {1'b0, mdu.SrcAE};
        mag_b  = neg_b ? -{1'b1, mdu.SrcBE} : {1'b0, mdu.SrcBE};
        accept = (state == IDLE) & mdu.MultStartE & ~mdu.MultAbortE;
        kill   = mdu.MultAbortE | ((state == RUN) & (hi_wr | lo_wr));
    end

    // One RUN cycle retires BPC bits; MULT shifts right, DIV shifts left.
    logic [WIDTH:0]   nxt_hi;
    logic [WIDTH:0]   nxt_lo;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH+1:0] sum;
    logic             qbit;

    always_comb begin
        nxt_hi  = acc_hi;
        nxt_lo  = acc_lo;
        shifted = '0;
        diff    = '0;
        sum     = '0;
        qbit    = 1'b0;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (op_div) begin
                shifted = {nxt_hi[WIDTH-1:0], nxt_lo[WIDTH-1]};
                diff    = {1'b0, shifted} - {1'b0, opnd};
                qbit    = ~diff[WIDTH+1];
                nxt_hi  = qbit ? diff[WIDTH:0] : shifted;
                nxt_lo  = {nxt_lo[WIDTH], nxt_lo[WIDTH-2:0], qbit};
            end else begin
                sum    = {1'b0, nxt_hi} + (nxt_lo[0] ? {1'b0, opnd} : '0);
                nxt_hi = sum[WIDTH+1:1];
                nxt_lo = {sum[0], nxt_lo[WIDTH:1]};
            end
        end
    end

    // Sign correction; min-int / -1 falls out naturally as quotient min-int, remainder 0.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH:1]};
        prod_s = neg_q ? -prod : prod;
        quo    = acc_lo[WIDTH-1:0];
        rem    = acc_hi[WIDTH-1:0];
        if (op_div) begin
            res_hi = neg_r ? -rem : rem;
            res_lo = div_zero ? '1 : (neg_q ? -quo : quo);
        end else begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div   <= mdu.MultOpE;
                        neg_q    <= neg_a ^ neg_b;
                        neg_r    <= neg_a;
                        div_zero <= mdu.MultOpE & (mdu.SrcBE == '0);
                        opnd     <= mdu.MultOpE ? mag_b : mag_a;
                        acc_lo   <= mdu.MultOpE ? mag_a : mag_b;
                        acc_hi   <= '0;
                        count    <= CW'(N);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        count  <= count - CW'(1);
                        if (count == CW'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!mdu.MultAbortE) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                        dz_q   <= div_zero;
                    end
                end
                default: state <= IDLE;
            endcase
            // A write in FIX lands after the result, so it wins while done still pulses.
            if (hi_wr) hi_q <= wr_data;
            if (lo_wr) lo_q <= wr_data;
        end
    end

    assign mdu.MultBusyE = (state == RUN) | (state == FIX);
    assign mdu.MultDoneE = done_q;
    assign mdu.DivZeroE  = dz_q;
    assign mdu.HiOut     = hi_q;
    assign mdu.LoOut     = lo_q;
endmodule
